// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - FSM state encoding (IDLE, LOAD, SEND, WAIT_LO, WAIT_HI) and the matching enum
//   - ASCII helper constants used by the byte requesters
//   - MAX_REQ: upper limit on the number of requesters (grant_id is 3 bits wide)
//   - next_index(): round-robin successor of an index, wrapping at n-1 -> 0
package uart_arb_pkg;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LOAD    = 3'd1;
   localparam logic [2:0] SEND    = 3'd2;
   localparam logic [2:0] WAIT_LO = 3'd3;
   localparam logic [2:0] WAIT_HI = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = IDLE,
      ST_LOAD    = LOAD,
      ST_SEND    = SEND,
      ST_WAIT_LO = WAIT_LO,
      ST_WAIT_HI = WAIT_HI
   } arb_state_e;

   localparam logic [7:0] ASC_R       = 8'h52;
   localparam logic [7:0] ASC_UP_BASE = 8'h40;
   localparam logic [7:0] ASC_LO_BASE = 8'h60;

   localparam int MAX_REQ = 8;

   function automatic int next_index(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational winner search plus a registered pointer.
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset (pointer returns to 0)
//   req_i        per-requester request vector
//   adv_i        advance the pointer past adv_id_i (one cycle, when a byte completes)
//   adv_id_i     index of the requester that was just served
//   grant_oh_o   one-hot winner (all zero when no request)
//   grant_idx_o  binary winner index
//   valid_o      at least one request present
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N_REQ-1:0] req_i,
   input  logic             adv_i,
   input  logic [PTR_W-1:0] adv_id_i,
   output logic [N_REQ-1:0] grant_oh_o,
   output logic [PTR_W-1:0] grant_idx_o,
   output logic             valid_o
);

   logic [PTR_W-1:0] ptr_q, ptr_d;

   // Scan requesters starting at the pointer; the first one found wins.
   always_comb begin
      int idx;
      idx         = 0;
      valid_o     = 1'b0;
      grant_idx_o = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(ptr_q) + i) % N_REQ;
         if (!valid_o && req_i[idx]) begin
            valid_o     = 1'b1;
            grant_idx_o = PTR_W'(idx);
         end
      end
      grant_oh_o = valid_o ? (N_REQ'(1) << grant_idx_o) : '0;
   end

   // The served requester drops to lowest priority for the next round.
   always_comb begin
      ptr_d = ptr_q;
      if (adv_i) begin
         ptr_d = PTR_W'(next_index(int'(adv_id_i), N_REQ));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte requesters with round-robin
// arbitration. The winner's byte is latched, SEND is pulsed once READY is high,
// and the READY high->low->high sequence marks the end of the frame, at which
// point the requester is acked.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset; abandons any byte in flight
//   req          per-requester request (held with stable data until ack)
//   req_data     byte of requester i at [8*i+7:8*i]
//   ack          one-cycle completion pulse for the granted requester
//   tx_ready     READY from the transmitter
//   tx_send      one-cycle SEND pulse to the transmitter
//   tx_data      latched byte, stable from grant until return to IDLE
//   busy         high whenever the FSM is not in IDLE
//   grant_id     index of the current/last granted requester
//   timeout_err  pulses together with ack when the transmitter stalls
// Build option:
//   UART_ARB_TIMEOUT_EN  adds a watchdog of TIMEOUT_CYC cycles on the READY
//                        handshake; without it timeout_err is tied low.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 262144
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   ack,
   input  logic               tx_ready,
   output logic               tx_send,
   output logic [7:0]         tx_data,
   output logic               busy,
   output logic [2:0]         grant_id,
   output logic               timeout_err
);

   localparam int PTR_W = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > MAX_REQ || TIMEOUT_CYC < 2) begin : g_bad_params
      $error("uart_tx_arbiter: N_REQ must be 2..MAX_REQ and TIMEOUT_CYC at least 2");
   end

   arb_state_e       state_q, state_d;
   logic [7:0]       data_q, data_d;
   logic [PTR_W-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic             send_q, send_d;
   logic             tout_q, tout_d;
   logic             adv;
   logic [N_REQ-1:0] win_oh;
   logic [PTR_W-1:0] win_idx;
   logic             win_valid;
   logic [7:0]       sel_data;
   logic             timeout_hit;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .clk_i       (clk),
      .rst_ni      (rst),
      .req_i       (req),
      .adv_i       (adv),
      .adv_id_i    (grant_q),
      .grant_oh_o  (win_oh),
      .grant_idx_o (win_idx),
      .valid_o     (win_valid)
   );

   // One-hot AND-OR mux of the winning requester's byte.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_oh[i]) begin
            sel_data = sel_data | req_data[8*i +: 8];
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC);

   logic [TW-1:0] tcnt_q, tcnt_d;

   // Held at zero while in SEND so the count starts fresh on entry to WAIT_LO.
   always_comb begin
      tcnt_d = tcnt_q;
      if (state_q == ST_SEND) begin
         tcnt_d = '0;
      end else if (state_q == ST_WAIT_LO || state_q == ST_WAIT_HI) begin
         tcnt_d = tcnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end

   assign timeout_hit = (state_q == ST_WAIT_LO || state_q == ST_WAIT_HI) &&
                        (tcnt_q == TW'(TIMEOUT_CYC - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      grant_d = grant_q;
      ack_d   = '0;
      send_d  = 1'b0;
      tout_d  = 1'b0;
      adv     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               data_d  = sel_data;
               grant_d = win_idx;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (tx_ready) begin
               send_d  = 1'b1;
               state_d = ST_WAIT_LO;
            end
         end
         ST_WAIT_LO: begin
            if (timeout_hit) begin
               ack_d   = N_REQ'(1) << grant_q;
               tout_d  = 1'b1;
               adv     = 1'b1;
               state_d = ST_IDLE;
            end else if (!tx_ready) begin
               state_d = ST_WAIT_HI;
            end
         end
         ST_WAIT_HI: begin
            // READY returning high means the frame has left the shifter.
            if (timeout_hit || tx_ready) begin
               ack_d   = N_REQ'(1) << grant_q;
               tout_d  = timeout_hit;
               adv     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         data_q  <= 8'h00;
         grant_q <= '0;
         ack_q   <= '0;
         send_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         send_q  <= send_d;
         tout_q  <= tout_d;
      end
   end

   assign ack         = ack_q;
   assign tx_send     = send_q;
   assign tx_data     = data_q;
   assign busy        = (state_q != ST_IDLE);
   assign grant_id    = 3'(grant_q);
   assign timeout_err = tout_q;

endmodule
